axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3 responder (slave) backed by an on-chip word-addressed RAM. It is the far end of our AXI initiator interface and serves as the bus target for CPU/cache bursts in SoC bring-up and simulation.
- Independent read and write engines run concurrently. Only INCR/FIXED bursts of 32-bit beats are supported; everything else gets SLVERR.

Parameters:
- MEM_AW, 10, log2 of RAM depth in 32-bit words (default 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 2^(MEM_AW+2).

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2  AW channel
- awlock/awcache/awprot  in  2/4/3  ignored
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  4  ignored (the initiator does not tie wid to awid)
- wdata/wstrb/wlast/wvalid  in  32/4/1/1  W channel
- wready  out  1  W ready
- bid/bresp/bvalid  out  4/2/1  B channel
- bready  in  1  B ready
- arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  AR channel
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  R channel
- rready  in  1  R ready

Behaviour:
- Reset (async, reset=0): both FSMs go to IDLE. All outputs are 0, including awready/arready. RAM contents are not reset.
- awready/arready are registered. They become 1 on the first clk edge after reset release, and again whenever the engine is IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready at edge N, latch arid, start address, arlen, burst, and err.
  - err=1 when any of: start address outside the window; arsize!=3'b010; arburst==WRAP (2'b10) or reserved (2'b11).
  - Also at edge N, load rdata with mem[word] (0 if err) and set rvalid=1 (visible from cycle N+1). arready drops to 0.
  - R_DATA: rdata/rresp/rlast/rid stay stable while rvalid&~rready.
  - On each rvalid&rready, if beat_cnt<len: increment beat_cnt, advance the address, and load the next beat at the same edge. Back-to-back beats run at one per cycle.
  - rlast=1 only when beat_cnt==len. The handshake on that beat drops rvalid and returns to R_IDLE, with arready=1 the next cycle.
  - rresp is 2'b10 (SLVERR) on every beat if err, otherwise 2'b00.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On handshake, latch awid, address, awlen, burst, and err (same rules as read), and go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes wdata byte lanes enabled by wstrb into mem[word]. The write is suppressed if err.
  - Beats are counted against awlen. The data phase ends on the beat where beat_cnt==awlen, or earlier if wlast=1.
  - Any wlast/count mismatch (early wlast, or missing wlast on the final beat) sets err.
  - The last W handshake at edge M gives bvalid=1 and wready=0 from cycle M+1. bid=latched awid; bresp=2'b10 if err, else 2'b00.
  - W_RESP: bvalid is held until bready. The handshake returns to W_IDLE.
- Address arithmetic:
  - word index = (addr - BASE_ADDR)[MEM_AW+1:2]; addr[1:0] is ignored.
  - INCR: index +1 per beat, wrapping modulo 2^MEM_AW (only the start address is range-checked).
  - FIXED: index is constant.
- Read/write on the same word in the same cycle: the read returns the old data.
- The two channels are fully independent; no ordering is enforced between reads and writes.
- A reset asserted mid-burst aborts the burst immediately. Partial writes already committed remain in RAM.

Decomposition:
- Package axi_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - BURST_FIXED/INCR/WRAP
  - SIZE_4B=3'b010
  - R_IDLE/R_DATA and W_IDLE/W_DATA/W_RESP state encodings
- One sub-module, sram_dp_bytewr: 2^MEM_AW x 32 dual-port array. It has a registered read port with enable, and a write port with a 4-bit byte enable. Read-during-write returns old data.

Test Plan:
- Single write: awaddr=0x10, awlen=0, awid=0xF, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1 -> bvalid one cycle after the W handshake, bid=0xF, bresp=00. Then arlen=0 read of 0x10 -> rdata=0xDEADBEEF, rlast=1, rid=0xF, rresp=00; rvalid asserts the cycle after the AR handshake.
- 16-beat INCR write at 0x100 with data 0..15, then arlen=15 read with rready=1 -> 16 consecutive rvalid cycles with rdata=i and rlast only on beat 15.
- Same read with rready toggled every other cycle -> rdata/rlast held stable while stalled; the sequence is still 0..15.
- Byte strobes: mem=0x11223344, write 0xAABBCCDD with wstrb=4'b0011 -> read returns 0x1122CCDD.
- Errors:
  - araddr=BASE_ADDR+0x4000 (outside default window), arlen=3 -> 4 beats, each rdata=0, rresp=10.
  - awburst=WRAP write -> bresp=10, RAM unchanged.
  - awlen=3 with wlast on beat 1 -> phase ends after 2 beats, bresp=10.
- Reset pulled low mid-read (beat 5 of 16) -> rvalid=0 asynchronously. arready=1 one edge after release; a fresh read of 0x100 returns 0.

Source files
------------

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 constants, FSM state encodings and request-checking helpers for
// the SRAM-backed AXI responder (axi_sram_slave) and its RAM macro.
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wstate_e;

  // A request is refused when it starts outside the window, is not a 32-bit
  // beat size, or uses WRAP or the reserved burst encoding.
  function automatic logic req_err(input logic       in_win,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
    logic bad_burst;
    case (burst)
      BURST_FIXED: bad_burst = 1'b0;
      BURST_INCR:  bad_burst = 1'b0;
      default:     bad_burst = 1'b1;
    endcase
    return (!in_win) || (size != SIZE_4B) || bad_burst;
  endfunction

  // Map a latched error flag onto the AXI response code.
  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/sram_dp_bytewr.sv
// -----------------------------------------------------------------------------
// sram_dp_bytewr
// 2^AW x 32-bit dual-port RAM: one registered read port with enable and one
// write port with per-byte enables. A read and write to the same word in the
// same cycle returns the old contents. Array contents are never reset; only
// the read output register is cleared so the bus sees zero out of reset.
// Ports:
//   clk, i_rst_n        clock / async active-low reset (output register only)
//   i_ren, i_raddr      read enable / word address
//   o_rdata             registered read data
//   i_wbe, i_waddr      byte write enables / word address
//   i_wdata             write data
// -----------------------------------------------------------------------------
module sram_dp_bytewr
  import axi_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_ren,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic [3:0]    i_wbe,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_q;

  // Byte-lane write into the storage array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wbe[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read port; holds its value while i_ren is low.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 32'h0000_0000;
    end else if (i_ren) begin
      r_q <= r_mem[i_raddr];
    end else begin
      r_q <= r_q;
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI3 responder backed by a word-addressed on-chip RAM. Independent read and
// write engines; INCR/FIXED bursts of 32-bit beats only, anything else SLVERR.
// Ports:
//   clk, reset                      clock / async active-low reset
//   aw*, awready                    write address channel (lock/cache/prot ignored)
//   w*, wready                      write data channel (wid ignored)
//   bid, bresp, bvalid, bready      write response channel
//   ar*, arready                    read address channel (lock/cache/prot ignored)
//   rid, rdata, rresp, rlast, rvalid, rready   read data channel
// -----------------------------------------------------------------------------
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int WIN_LSB = MEM_AW + 2;

  // Sideband fields the responder deliberately does not interpret.
  logic w_unused_ok;
  assign w_unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                         wid, awaddr[1:0], araddr[1:0]};

  // Window check works on the high bits because BASE_ADDR is window-aligned,
  // which also makes the word index simply the low address bits.
  logic              w_ar_err, w_aw_err;
  logic [MEM_AW-1:0] w_ar_idx, w_aw_idx;
  assign w_ar_err = req_err(araddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB], arsize, arburst);
  assign w_aw_err = req_err(awaddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB], awsize, awburst);
  assign w_ar_idx = araddr[WIN_LSB-1:2];
  assign w_aw_idx = awaddr[WIN_LSB-1:2];

  // ---------------------------------------------------------------- read ----
  rstate_e           r_rstate, w_rstate_nxt;
  logic              r_arready, r_rlast, r_rerr, r_rfixed;
  logic [3:0]        r_rid, r_rlen, r_rbeat;
  logic [MEM_AW-1:0] r_ridx, w_ridx_next, w_raddr;
  logic              w_ren, w_ar_hs, w_r_hs, w_r_more, w_r_done;
  logic [31:0]       w_ram_q;

  assign w_ar_hs     = arvalid & r_arready;
  assign w_r_hs      = (r_rstate == R_DATA) & rready;
  assign w_r_more    = w_r_hs & (r_rbeat != r_rlen);
  assign w_r_done    = w_r_hs & (r_rbeat == r_rlen);
  assign w_ridx_next = r_rfixed ? r_ridx : r_ridx + MEM_AW'(1);

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read FSM next-state logic.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)  w_rstate_nxt = R_DATA; else w_rstate_nxt = R_IDLE;
      R_DATA:  if (w_r_done) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_DATA;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM outputs: RAM fetch on acceptance and on each non-final beat.
  always_comb begin
    w_ren   = 1'b0;
    w_raddr = r_ridx;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)  begin w_ren = 1'b1; w_raddr = w_ar_idx;    end
               else          begin w_ren = 1'b0; w_raddr = r_ridx;      end
      R_DATA:  if (w_r_more) begin w_ren = 1'b1; w_raddr = w_ridx_next; end
               else          begin w_ren = 1'b0; w_raddr = r_ridx;      end
      default: begin w_ren = 1'b0; w_raddr = r_ridx; end
    endcase
  end

  // Read burst bookkeeping and registered channel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arready <= 1'b0;
      r_rid     <= 4'd0;
      r_rlen    <= 4'd0;
      r_rbeat   <= 4'd0;
      r_rerr    <= 1'b0;
      r_rfixed  <= 1'b0;
      r_rlast   <= 1'b0;
      r_ridx    <= '0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_rlen   <= arlen;
        r_rbeat  <= 4'd0;
        r_rerr   <= w_ar_err;
        r_rfixed <= (arburst == BURST_FIXED);
        r_rlast  <= (arlen == 4'd0);
        r_ridx   <= w_ar_idx;
      end else if (w_r_more) begin
        r_rbeat  <= r_rbeat + 4'd1;
        r_ridx   <= w_ridx_next;
        r_rlast  <= ((r_rbeat + 4'd1) == r_rlen);
      end else if (w_r_done) begin
        r_rlast  <= 1'b0;
      end else begin
        r_rlast  <= r_rlast;
      end
    end
  end

  assign arready = r_arready;
  assign rvalid  = (r_rstate == R_DATA);
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rresp   = resp_of(r_rerr);
  assign rdata   = r_rerr ? 32'h0000_0000 : w_ram_q;

  // --------------------------------------------------------------- write ----
  wstate_e           r_wstate, w_wstate_nxt;
  logic              r_awready, r_werr, r_wfixed;
  logic [3:0]        r_wid, r_wlen, r_wbeat, w_wbe;
  logic [MEM_AW-1:0] r_widx;
  logic              w_aw_hs, w_w_hs, w_w_final, w_w_end, w_w_mis, w_b_hs;

  assign w_aw_hs   = awvalid & r_awready;
  assign w_w_hs    = (r_wstate == W_DATA) & wvalid;
  assign w_w_final = (r_wbeat == r_wlen);
  assign w_w_end   = w_w_hs & (w_w_final | wlast);
  // wlast must coincide exactly with the counted final beat.
  assign w_w_mis   = w_w_hs & (w_w_final != wlast);
  assign w_b_hs    = (r_wstate == W_RESP) & bready;
  assign w_wbe     = (w_w_hs & ~r_werr & ~w_w_mis) ? wstrb : 4'h0;

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write FSM next-state logic.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA; else w_wstate_nxt = W_IDLE;
      W_DATA:  if (w_w_end) w_wstate_nxt = W_RESP; else w_wstate_nxt = W_DATA;
      W_RESP:  if (w_b_hs)  w_wstate_nxt = W_IDLE; else w_wstate_nxt = W_RESP;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM outputs: channel handshakes decoded from the state register.
  always_comb begin
    wready = 1'b0;
    bvalid = 1'b0;
    case (r_wstate)
      W_IDLE:  begin wready = 1'b0; bvalid = 1'b0; end
      W_DATA:  begin wready = 1'b1; bvalid = 1'b0; end
      W_RESP:  begin wready = 1'b0; bvalid = 1'b1; end
      default: begin wready = 1'b0; bvalid = 1'b0; end
    endcase
  end

  // Write burst bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_awready <= 1'b0;
      r_wid     <= 4'd0;
      r_wlen    <= 4'd0;
      r_wbeat   <= 4'd0;
      r_werr    <= 1'b0;
      r_wfixed  <= 1'b0;
      r_widx    <= '0;
    end else begin
      r_awready <= (w_wstate_nxt == W_IDLE);
      if (w_aw_hs) begin
        r_wid    <= awid;
        r_wlen   <= awlen;
        r_wbeat  <= 4'd0;
        r_werr   <= w_aw_err;
        r_wfixed <= (awburst == BURST_FIXED);
        r_widx   <= w_aw_idx;
      end else if (w_w_hs) begin
        r_wbeat  <= r_wbeat + 4'd1;
        r_widx   <= r_wfixed ? r_widx : r_widx + MEM_AW'(1);
        r_werr   <= r_werr | w_w_mis;
      end else begin
        r_wbeat  <= r_wbeat;
      end
    end
  end

  assign awready = r_awready;
  assign bid     = r_wid;
  assign bresp   = resp_of(r_werr);

  sram_dp_bytewr #(.AW(MEM_AW)) u_ram (
    .clk     (clk),
    .i_rst_n (reset),
    .i_ren   (w_ren),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q),
    .i_wbe   (w_wbe),
    .i_waddr (r_widx),
    .i_wdata (wdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed self-checking bench for axi_sram_slave: single beats, INCR bursts
// with and without R back-pressure, byte strobes, error responses and an
// asynchronous reset in the middle of a read burst.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid, arid, wid;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  awlen, arlen, awcache, arcache, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock;
  logic        awvalid, wlast, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] wr_q  [16];
  logic [31:0] exp_q [16];

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic wr_burst(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [1:0] burst, input int nbeats, input int last_at,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int cnt;
    awaddr = addr; awlen = len; awid = id; awburst = burst; awsize = 3'b010; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 20) begin tick(); cnt++; end
    chk("awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wr_q[b]; wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
      cnt = 0;
      while (!wready && cnt < 20) begin tick(); cnt++; end
      chk("wready", {31'd0, wready}, 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_rise", {31'd0, bvalid}, 32'd1);
    chk("wready_drop", {31'd0, wready}, 32'd0);
    chk("bid", {28'd0, bid}, {28'd0, id});
    chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("awready_back", {31'd0, awready}, 32'd1);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input bit toggle, input logic [1:0] exp_resp);
    int cnt;
    int i;
    int cyc;
    araddr = addr; arlen = len; arid = id; arburst = 2'b01; arsize = 3'b010; arvalid = 1'b1;
    cnt = 0;
    while (!arready && cnt < 20) begin tick(); cnt++; end
    chk("arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    i = 0;
    cyc = 0;
    while (i <= int'(len) && cyc < 80) begin
      rready = toggle ? cyc[0] : 1'b1;
      chk("rvalid", {31'd0, rvalid}, 32'd1);
      chk("rdata", rdata, exp_q[i]);
      chk("rlast", {31'd0, rlast}, (i == int'(len)) ? 32'd1 : 32'd0);
      chk("rid", {28'd0, rid}, {28'd0, id});
      chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
      if (rready) i++;
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
    chk("arready_back", {31'd0, arready}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'b010; awburst = 2'b01;
    awlock = 2'd0; awcache = 4'd0; awprot = 3'd0; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01;
    arlock = 2'd0; arcache = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    #12;
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    reset = 1'b1;
    tick();
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_arready", {31'd0, arready}, 32'd1);

    // Single write then single read
    wr_q[0] = 32'hDEAD_BEEF;
    wr_burst(32'h10, 4'd0, 4'hF, 2'b01, 1, 0, 4'hF, 2'b00);
    exp_q[0] = 32'hDEAD_BEEF;
    rd_burst(32'h10, 4'd0, 4'hF, 1'b0, 2'b00);

    // 16-beat INCR write, then full-rate and throttled reads
    for (int k = 0; k < 16; k++) begin wr_q[k] = k; exp_q[k] = k; end
    wr_burst(32'h100, 4'd15, 4'h3, 2'b01, 16, 15, 4'hF, 2'b00);
    rd_burst(32'h100, 4'd15, 4'h5, 1'b0, 2'b00);
    rd_burst(32'h100, 4'd15, 4'h6, 1'b1, 2'b00);

    // Byte strobes
    wr_q[0] = 32'h1122_3344;
    wr_burst(32'h20, 4'd0, 4'h1, 2'b01, 1, 0, 4'hF, 2'b00);
    wr_q[0] = 32'hAABB_CCDD;
    wr_burst(32'h20, 4'd0, 4'h2, 2'b01, 1, 0, 4'b0011, 2'b00);
    exp_q[0] = 32'h1122_CCDD;
    rd_burst(32'h20, 4'd0, 4'h2, 1'b0, 2'b00);

    // Out-of-window read: four zero beats with SLVERR
    for (int k = 0; k < 4; k++) exp_q[k] = 32'd0;
    rd_burst(32'h4000, 4'd3, 4'h7, 1'b0, 2'b10);

    // WRAP write refused, RAM untouched
    wr_q[0] = 32'h1234_5678;
    wr_burst(32'h10, 4'd0, 4'h8, 2'b10, 1, 0, 4'hF, 2'b10);
    exp_q[0] = 32'hDEAD_BEEF;
    rd_burst(32'h10, 4'd0, 4'h8, 1'b0, 2'b00);

    // Early wlast on beat 1 of a 4-beat burst
    wr_q[0] = 32'h5555_0000; wr_q[1] = 32'h5555_0001;
    wr_burst(32'h200, 4'd3, 4'h9, 2'b01, 2, 1, 4'hF, 2'b10);

    // Reset in the middle of a 16-beat read
    araddr = 32'h100; arlen = 4'd15; arid = 4'hA; arburst = 2'b01; arsize = 3'b010;
    arvalid = 1'b1;
    chk("mid_arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_beat5", rdata, 32'd5);
    rready = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rvalid_async", {31'd0, rvalid},  32'd0);
    chk("mid_arready_rst",  {31'd0, arready}, 32'd0);
    #3;
    reset = 1'b1;
    tick();
    chk("mid_arready_rel", {31'd0, arready}, 32'd1);
    exp_q[0] = 32'd0;
    rd_burst(32'h100, 4'd0, 4'hB, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
